// File: rtl/arf_sequencer.sv
// arf_sequencer: turns single-cycle PC/SP/stack requests into per-cycle ARF and memory control steps.
// Optional stack bound checking is enabled with `ARF_SEQ_STACKCHK_EN (adds i_sp_value and the bounds parameters).
module arf_sequencer
`ifdef ARF_SEQ_STACKCHK_EN
#(
  parameter logic [15:0] STACK_TOP   = 16'hFFFF,
  parameter logic [15:0] STACK_LIMIT = 16'hFF00
)
`endif
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [2:0]  i_op,
`ifdef ARF_SEQ_STACKCHK_EN
  input  logic [15:0] i_sp_value,
`endif
  output logic [2:0]  o_fun_sel,
  output logic [2:0]  o_reg_sel,
  output logic [1:0]  o_outc_sel,
  output logic [1:0]  o_outd_sel,
  output logic [1:0]  o_isel,
  output logic        o_wdata_sel,
  output logic        o_mem_en,
  output logic        o_mem_wr,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_INCPC = 3'b001;
  localparam logic [2:0] OP_JUMP  = 3'b010;
  localparam logic [2:0] OP_PUSH  = 3'b011;
  localparam logic [2:0] OP_POP   = 3'b100;
  localparam logic [2:0] OP_CALL  = 3'b101;
  localparam logic [2:0] OP_RET   = 3'b110;
  localparam logic [2:0] OP_RSVD  = 3'b111;

  localparam logic [2:0] FS_DEC  = 3'b000;
  localparam logic [2:0] FS_INC  = 3'b001;
  localparam logic [2:0] FS_LOAD = 3'b010;

  localparam logic [2:0] RS_NONE = 3'b111;
  localparam logic [2:0] RS_PC   = 3'b011;
  localparam logic [2:0] RS_AR   = 3'b101;
  localparam logic [2:0] RS_SP   = 3'b110;

  localparam logic [1:0] OUTC_PC  = 2'b00;
  localparam logic [1:0] OUTD_SP  = 2'b11;
  localparam logic [1:0] ISEL_TGT = 2'b00;
  localparam logic [1:0] ISEL_MEM = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S1   = 2'd1,
    S2   = 2'd2,
    S3   = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_op;
  logic       r_rej;
  logic       w_accept;
  logic       w_rej_req;
  logic       w_single;
  logic       w_last;

  assign w_accept = (r_state == IDLE) && i_start && (i_op != OP_NOP);

`ifdef ARF_SEQ_STACKCHK_EN
  // Bounds are judged on the SP value present at the accepting edge.
  always_comb begin
    w_rej_req = 1'b0;
    case (i_op)
      OP_PUSH, OP_CALL: w_rej_req = (i_sp_value == STACK_LIMIT);
      OP_POP,  OP_RET:  w_rej_req = (i_sp_value == STACK_TOP);
      default:          w_rej_req = 1'b0;
    endcase
  end
`else
  assign w_rej_req = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_op    <= OP_NOP;
      r_rej   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op  <= i_op;
        r_rej <= w_rej_req;
      end
    end
  end

  assign w_single = r_rej || (r_op == OP_INCPC) || (r_op == OP_JUMP) || (r_op == OP_RSVD);

  always_comb begin
    w_next      = r_state;
    w_last      = 1'b0;
    o_fun_sel   = FS_DEC;
    o_reg_sel   = RS_NONE;
    o_outc_sel  = OUTC_PC;
    o_outd_sel  = OUTD_SP;
    o_isel      = ISEL_TGT;
    o_wdata_sel = 1'b0;
    o_mem_en    = 1'b0;
    o_mem_wr    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next = S1;
      end
      S1: begin
        w_last = w_single;
        w_next = w_single ? IDLE : S2;
        if (!r_rej) begin
          case (r_op)
            OP_INCPC: begin
              o_fun_sel = FS_INC;
              o_reg_sel = RS_PC;
            end
            OP_JUMP: begin
              o_fun_sel = FS_LOAD;
              o_reg_sel = RS_PC;
              o_isel    = ISEL_TGT;
            end
            OP_PUSH, OP_CALL: begin
              o_fun_sel = FS_DEC;
              o_reg_sel = RS_SP;
            end
            OP_POP, OP_RET: begin
              o_mem_en = 1'b1;
              o_mem_wr = 1'b0;
            end
            default: ;
          endcase
        end
      end
      S2: begin
        w_last = (r_op == OP_PUSH);
        w_next = w_last ? IDLE : S3;
        case (r_op)
          OP_PUSH: begin
            o_mem_en    = 1'b1;
            o_mem_wr    = 1'b1;
            o_wdata_sel = 1'b0;
          end
          OP_CALL: begin
            o_mem_en    = 1'b1;
            o_mem_wr    = 1'b1;
            o_outc_sel  = OUTC_PC;
            o_wdata_sel = 1'b1;
          end
          // Read data from S1 is valid now, so the load lands here.
          OP_POP: begin
            o_fun_sel = FS_LOAD;
            o_reg_sel = RS_AR;
            o_isel    = ISEL_MEM;
          end
          OP_RET: begin
            o_fun_sel = FS_LOAD;
            o_reg_sel = RS_PC;
            o_isel    = ISEL_MEM;
          end
          default: ;
        endcase
      end
      S3: begin
        w_last = 1'b1;
        w_next = IDLE;
        case (r_op)
          OP_POP, OP_RET: begin
            o_fun_sel = FS_INC;
            o_reg_sel = RS_SP;
          end
          OP_CALL: begin
            o_fun_sel = FS_LOAD;
            o_reg_sel = RS_PC;
            o_isel    = ISEL_TGT;
          end
          default: ;
        endcase
      end
      default: w_next = IDLE;
    endcase
  end

  assign o_busy = (r_state != IDLE);
  assign o_done = w_last;
  assign o_err  = w_last && (r_state == S1) && (r_rej || (r_op == OP_RSVD));

endmodule

// File: tb/tb_arf_sequencer.sv
// Bench for arf_sequencer: a register-file/memory environment plus a command-level reference model.
module tb_arf_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [2:0]  fun_sel, reg_sel;
  logic [1:0]  outc_sel, outd_sel, isel;
  logic        wdata_sel, mem_en, mem_wr, busy, done, err;

  logic [15:0] pc = 16'd0, ar = 16'd0, sp = 16'd0, rdata = 16'd0;
  logic [15:0] target = 16'd0, ext_data = 16'd0;
  logic [15:0] mem [0:65535];
  int          n_checks = 0;
  int          n_pass = 0;
  int          reg_wr_cnt = 0;
  int          mem_cnt = 0;

  logic        seed_req = 1'b0;
  logic [15:0] seed_pc = 16'd0, seed_ar = 16'd0, seed_sp = 16'd0, seed_addr = 16'd0, seed_data = 16'd0;

  localparam logic [17:0] IDLE_V = {3'b000, 3'b111, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;

  arf_sequencer dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_op        (op),
`ifdef ARF_SEQ_STACKCHK_EN
    .i_sp_value  (sp),
`endif
    .o_fun_sel   (fun_sel),
    .o_reg_sel   (reg_sel),
    .o_outc_sel  (outc_sel),
    .o_outd_sel  (outd_sel),
    .o_isel      (isel),
    .o_wdata_sel (wdata_sel),
    .o_mem_en    (mem_en),
    .o_mem_wr    (mem_wr),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err)
  );

  wire [17:0] obs_v = {fun_sel, reg_sel, outc_sel, outd_sel, isel, wdata_sel, mem_en, mem_wr, busy, done, err};
  wire [15:0] ival  = (isel == 2'b01) ? rdata : target;

  function automatic logic [15:0] fn(input logic [2:0] fs, input logic [15:0] q, input logic [15:0] i);
    case (fs)
      3'd0:    return q - 16'd1;
      3'd1:    return q + 16'd1;
      3'd2:    return i;
      3'd3:    return 16'd0;
      default: return q;
    endcase
  endfunction

  // Environment: address register file and stack memory driven by the DUT controls.
  always @(posedge clk) begin
    if (seed_req) begin
      pc <= seed_pc;
      ar <= seed_ar;
      sp <= seed_sp;
      mem[seed_addr] <= seed_data;
    end else begin
      if (!reg_sel[2]) pc <= fn(fun_sel, pc, ival);
      if (!reg_sel[1]) ar <= fn(fun_sel, ar, ival);
      if (!reg_sel[0]) sp <= fn(fun_sel, sp, ival);
      if (reg_sel != 3'b111) reg_wr_cnt <= reg_wr_cnt + 1;
      if (mem_en) begin
        mem_cnt <= mem_cnt + 1;
        if (mem_wr) mem[sp] <= wdata_sel ? pc : ext_data;
        else        rdata   <= mem[sp];
      end
    end
  end

  function automatic logic [17:0] mk(input logic [2:0] f, input logic [2:0] r, input logic [1:0] oc,
                                     input logic [1:0] od, input logic [1:0] is, input logic wd,
                                     input logic me, input logic mw, input logic dn, input logic er);
    return {f, r, oc, od, is, wd, me, mw, 1'b1, dn, er};
  endfunction

  function automatic logic [17:0] exp_step(input logic [2:0] o, input int k, input logic rj, input int lat);
    logic dn;
    dn = (k == lat);
    if (rj || o == 3'd7) return mk(3'd0, 3'b111, 2'd0, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    case (o)
      3'd1: return mk(3'd1, 3'b011, 2'd0, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, dn, 1'b0);
      3'd2: return mk(3'd2, 3'b011, 2'd0, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, dn, 1'b0);
      3'd3: if (k == 1) return mk(3'd0, 3'b110, 2'd0, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, dn, 1'b0);
            else        return mk(3'd0, 3'b111, 2'd0, 2'd3, 2'd0, 1'b0, 1'b1, 1'b1, dn, 1'b0);
      3'd4: if (k == 1)      return mk(3'd0, 3'b111, 2'd0, 2'd3, 2'd0, 1'b0, 1'b1, 1'b0, dn, 1'b0);
            else if (k == 2) return mk(3'd2, 3'b101, 2'd0, 2'd3, 2'd1, 1'b0, 1'b0, 1'b0, dn, 1'b0);
            else             return mk(3'd1, 3'b110, 2'd0, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, dn, 1'b0);
      3'd5: if (k == 1)      return mk(3'd0, 3'b110, 2'd0, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, dn, 1'b0);
            else if (k == 2) return mk(3'd0, 3'b111, 2'd0, 2'd3, 2'd0, 1'b1, 1'b1, 1'b1, dn, 1'b0);
            else             return mk(3'd2, 3'b011, 2'd0, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, dn, 1'b0);
      default: if (k == 1)      return mk(3'd0, 3'b111, 2'd0, 2'd3, 2'd0, 1'b0, 1'b1, 1'b0, dn, 1'b0);
               else if (k == 2) return mk(3'd2, 3'b011, 2'd0, 2'd3, 2'd1, 1'b0, 1'b0, 1'b0, dn, 1'b0);
               else             return mk(3'd1, 3'b110, 2'd0, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, dn, 1'b0);
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] o, input logic rj);
    if (rj || o == 3'd1 || o == 3'd2 || o == 3'd7) return 1;
    if (o == 3'd3) return 2;
    return 3;
  endfunction

  function automatic logic rej_of(input logic [2:0] o, input logic [15:0] s);
`ifdef ARF_SEQ_STACKCHK_EN
    return ((o == 3'd3 || o == 3'd5) && s == 16'hFF00) || ((o == 3'd4 || o == 3'd6) && s == 16'hFFFF);
`else
    return 1'b0 & (^{o, s});
`endif
  endfunction

  task automatic seed(input logic [15:0] p, input logic [15:0] a, input logic [15:0] s,
                      input logic [15:0] addr, input logic [15:0] data);
    seed_pc = p; seed_ar = a; seed_sp = s; seed_addr = addr; seed_data = data;
    seed_req = 1'b1;
    @(posedge clk); #1;
    seed_req = 1'b0;
  endtask

  // Issues one command from IDLE, checks every step, then checks the architectural result.
  task automatic run_cmd(input logic [2:0] o, input logic [15:0] tgt, input logic [15:0] ext);
    logic [15:0] e_pc, e_ar, e_sp, e_m, a;
    logic        rj;
    int          lat;
    if (o == 3'd0) begin
      start = 1'b1; op = 3'd0;
      @(posedge clk); #1;
      start = 1'b0;
      n_checks++;
      if (obs_v !== IDLE_V) $display("FAIL nop_ignored: got %h expected %h", obs_v, IDLE_V);
      else n_pass++;
      return;
    end
    rj  = rej_of(o, sp);
    lat = lat_of(o, rj);
    a   = sp - 16'd1;
    e_pc = pc; e_ar = ar; e_sp = sp; e_m = mem[a];
    if (!rj) begin
      case (o)
        3'd1: e_pc = pc + 16'd1;
        3'd2: e_pc = tgt;
        3'd3: begin e_sp = sp - 16'd1; e_m = ext; end
        3'd4: begin e_ar = mem[sp]; e_sp = sp + 16'd1; end
        3'd5: begin e_sp = sp - 16'd1; e_m = pc; e_pc = tgt; end
        3'd6: begin e_pc = mem[sp]; e_sp = sp + 16'd1; end
        default: ;
      endcase
    end
    target = tgt; ext_data = ext;
    start = 1'b1; op = o;
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (obs_v !== exp_step(o, k, rj, lat))
        $display("FAIL step op=%0d k=%0d: got %h expected %h", o, k, obs_v, exp_step(o, k, rj, lat));
      else n_pass++;
      start = 1'($urandom_range(0, 1));
      op    = 3'($urandom_range(0, 7));
    end
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (obs_v !== IDLE_V) $display("FAIL idle_after op=%0d: got %h expected %h", o, obs_v, IDLE_V);
    else n_pass++;
    n_checks++;
    if ({pc, ar, sp, mem[a]} !== {e_pc, e_ar, e_sp, e_m})
      $display("FAIL result op=%0d: got pc/ar/sp/m %h %h %h %h expected %h %h %h %h",
               o, pc, ar, sp, mem[a], e_pc, e_ar, e_sp, e_m);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; op = 3'd5;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (obs_v !== IDLE_V) $display("FAIL reset_outputs: got %h expected %h", obs_v, IDLE_V);
    else n_pass++;
    start = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (obs_v !== IDLE_V) $display("FAIL reset_release: got %h expected %h", obs_v, IDLE_V);
    else n_pass++;
  endtask

  task automatic test_push();
    seed(16'h0000, 16'h0000, 16'h0100, 16'h00FF, 16'h0000);
    run_cmd(3'd3, 16'h0000, 16'hBEEF);
    n_checks++;
    if ({sp, mem[16'h00FF]} !== {16'h00FF, 16'hBEEF})
      $display("FAIL push_sp_mem: got %h %h expected 00ff beef", sp, mem[16'h00FF]);
    else n_pass++;
  endtask

  task automatic test_call_ret();
    seed(16'h0040, 16'h0000, 16'h0100, 16'h00FF, 16'h5555);
    run_cmd(3'd5, 16'h1234, 16'h0000);
    n_checks++;
    if ({pc, sp, mem[16'h00FF]} !== {16'h1234, 16'h00FF, 16'h0040})
      $display("FAIL call_effects: got %h %h %h expected 1234 00ff 0040", pc, sp, mem[16'h00FF]);
    else n_pass++;
    run_cmd(3'd6, 16'h0000, 16'h0000);
    n_checks++;
    if ({pc, sp} !== {16'h0040, 16'h0100})
      $display("FAIL ret_effects: got %h %h expected 0040 0100", pc, sp);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    seed(16'h0100, 16'h0000, 16'h0200, 16'h0000, 16'h0000);
    start = 1'b1; op = 3'd1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (busy !== ((k % 2) == 1)) $display("FAIL b2b_busy k=%0d: got %b expected %b", k, busy, (k % 2) == 1);
      else n_pass++;
    end
    start = 1'b0;
    n_checks++;
    if (pc !== 16'h010A) $display("FAIL b2b_pc: got %h expected 010a", pc);
    else n_pass++;
  endtask

  task automatic test_reserved();
    int r0, m0;
    seed(16'h2222, 16'h3333, 16'h4444, 16'h4443, 16'h7777);
    r0 = reg_wr_cnt; m0 = mem_cnt;
    run_cmd(3'd7, 16'h9999, 16'h8888);
    n_checks++;
    if ({reg_wr_cnt, mem_cnt} !== {r0, m0})
      $display("FAIL rsvd_no_action: got %0d %0d expected %0d %0d", reg_wr_cnt, mem_cnt, r0, m0);
    else n_pass++;
  endtask

  task automatic test_reset_mid_call();
    seed(16'h0040, 16'h0000, 16'h0100, 16'h00FF, 16'hAAAA);
    target = 16'h1234; start = 1'b1; op = 3'd5;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (obs_v !== exp_step(3'd5, 2, 1'b0, 3)) $display("FAIL mid_call_s2: got %h expected %h", obs_v, exp_step(3'd5, 2, 1'b0, 3));
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if (obs_v !== IDLE_V) $display("FAIL mid_call_abort: got %h expected %h", obs_v, IDLE_V);
    else n_pass++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if ({obs_v, pc, sp, mem[16'h00FF]} !== {IDLE_V, 16'h0040, 16'h00FF, 16'hAAAA})
      $display("FAIL mid_call_effects: got %h %h %h %h expected idle 0040 00ff aaaa", obs_v, pc, sp, mem[16'h00FF]);
    else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

`ifdef ARF_SEQ_STACKCHK_EN
  task automatic test_stackchk();
    int r0, m0;
    seed(16'h0040, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h1111);
    r0 = reg_wr_cnt; m0 = mem_cnt;
    run_cmd(3'd6, 16'h0000, 16'h0000);
    run_cmd(3'd4, 16'h0000, 16'h0000);
    seed(16'h0040, 16'h0000, 16'hFF00, 16'hFEFF, 16'h2222);
    run_cmd(3'd3, 16'h0000, 16'h3333);
    run_cmd(3'd5, 16'h5678, 16'h0000);
    n_checks++;
    if ({reg_wr_cnt, mem_cnt} !== {r0, m0})
      $display("FAIL stackchk_no_action: got %0d %0d expected %0d %0d", reg_wr_cnt, mem_cnt, r0, m0);
    else n_pass++;
    seed(16'h0040, 16'h0000, 16'hFF01, 16'hFF00, 16'h0000);
    run_cmd(3'd3, 16'h0000, 16'h4444);
  endtask
`endif

  task automatic test_random();
    logic [15:0] s;
    logic [2:0]  o;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 4))
        0:       s = 16'hFFFF;
        1:       s = 16'hFF00;
        2:       s = 16'h0000;
        3:       s = 16'hFF01;
        default: s = 16'($urandom);
      endcase
      o = 3'($urandom_range(0, 7));
      seed(16'($urandom), 16'($urandom), s, s, 16'($urandom));
      seed(pc, ar, s, s - 16'd1, 16'($urandom));
      run_cmd(o, 16'($urandom), 16'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_push();
    test_call_ret();
    test_back_to_back();
    test_reserved();
    test_reset_mid_call();
`ifdef ARF_SEQ_STACKCHK_EN
    test_stackchk();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
